// File: rtl/keypad_scan_if.sv
// keypad_scan_if
// Bundles the keypad pin side (row/col) with the decoded key outputs.
//   row       : asynchronous row lines from the matrix, active-high
//   col       : one-hot active-high column drive
//   key_code  : last accepted key, {row_idx, col_idx}
//   key_valid : one-cycle pulse when a key is accepted
//   key_held  : high while the accepted key is still pressed
// master : the scan controller; slave : the keypad/consumer side.
interface keypad_scan_if;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    modport master (
        input  row,
        output col,
        output key_code,
        output key_valid,
        output key_held
    );

    modport slave (
        output row,
        input  col,
        input  key_code,
        input  key_valid,
        input  key_held
    );
endinterface

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl
// 4x4 matrix keypad scanner. Drives one column at a time, synchronizes the
// row lines through two flops, debounces the first detected key and emits a
// one-cycle key_valid pulse with the encoded key.
//
// Ports:
//   clk : single clock domain
//   rst : synchronous active-high reset
//   kp  : keypad_scan_if.master (row in; col, key_code, key_valid, key_held out)
//
// Parameters:
//   SCAN_DIV   : cycles each column stays driven while scanning (>=2)
//   STABLE_CNT : consecutive stable cycles to accept a press or a release (>=1)
//   REPEAT_DLY : auto-repeat period in cycles
//
// Build option: define KEYPAD_REPEAT_EN to re-pulse key_valid every
// REPEAT_DLY cycles while a key stays pressed.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// S_SCAN     | rotate col, sample row_s at the end of each dwell period
// S_DEBOUNCE | col frozen, wait for STABLE_CNT matches of the latched pattern
// S_PRESSED  | key accepted, key_held=1, wait for all rows to read zero
// S_RELEASE  | wait for STABLE_CNT consecutive zeros before resuming the scan
module keypad_scan_ctrl #(
    parameter int SCAN_DIV   = 16,
    parameter int STABLE_CNT = 26,
    parameter int REPEAT_DLY = 1000000
) (
    input  logic          clk,
    input  logic          rst,
    keypad_scan_if.master kp
);

    localparam int DW = (SCAN_DIV   > 1) ? $clog2(SCAN_DIV)   : 1;
    localparam int SW = (STABLE_CNT > 1) ? $clog2(STABLE_CNT) : 1;

    localparam logic [DW-1:0] DWELL_LAST  = DW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CNT - 1);

`ifdef KEYPAD_REPEAT_EN
    localparam int RW = (REPEAT_DLY > 1) ? $clog2(REPEAT_DLY) : 1;
    localparam logic [RW-1:0] REPEAT_LAST = RW'(REPEAT_DLY - 1);
`endif

    typedef enum logic [1:0] {
        S_SCAN,
        S_DEBOUNCE,
        S_PRESSED,
        S_RELEASE
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    row_meta, row_s;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [SW-1:0] stable_q, stable_d;
    logic [3:0]    col_q, col_d;
    logic [3:0]    row_pat_q, row_pat_d;
    logic [1:0]    col_idx_q, col_idx_d;
    logic [3:0]    key_code_q, key_code_d;
    logic          key_valid_q, key_valid_d;
    logic          key_held_q, key_held_d;
`ifdef KEYPAD_REPEAT_EN
    logic [RW-1:0] rep_q, rep_d;
`endif

    logic [3:0]    col_next;

    // Lowest set row wins when several keys share the driven column.
    function automatic logic [1:0] low_idx(input logic [3:0] p);
        if (p[0])      return 2'd0;
        else if (p[1]) return 2'd1;
        else if (p[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    function automatic logic [1:0] col_enc(input logic [3:0] c);
        if (c[0])      return 2'd0;
        else if (c[1]) return 2'd1;
        else if (c[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    assign col_next = {col_q[2:0], col_q[3]};

    always_ff @(posedge clk) begin
        if (rst) begin
            row_meta    <= '0;
            row_s       <= '0;
            state_q     <= S_SCAN;
            dwell_q     <= '0;
            stable_q    <= '0;
            col_q       <= 4'b0001;
            row_pat_q   <= '0;
            col_idx_q   <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_q       <= '0;
`endif
        end else begin
            row_meta    <= kp.row;
            row_s       <= row_meta;
            state_q     <= state_d;
            dwell_q     <= dwell_d;
            stable_q    <= stable_d;
            col_q       <= col_d;
            row_pat_q   <= row_pat_d;
            col_idx_q   <= col_idx_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
`ifdef KEYPAD_REPEAT_EN
            rep_q       <= rep_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        dwell_d     = dwell_q;
        stable_d    = stable_q;
        col_d       = col_q;
        row_pat_d   = row_pat_q;
        col_idx_d   = col_idx_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;
`ifdef KEYPAD_REPEAT_EN
        rep_d       = rep_q;
`endif

        unique case (state_q)
            S_SCAN: begin
                if (dwell_q == DWELL_LAST) begin
                    dwell_d = '0;
                    if (row_s == 4'b0000) begin
                        col_d = col_next;
                    end else begin
                        row_pat_d = row_s;
                        col_idx_d = col_enc(col_q);
                        stable_d  = '0;
                        state_d   = S_DEBOUNCE;
                    end
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end

            S_DEBOUNCE: begin
                if (row_s == row_pat_q) begin
                    if (stable_q == STABLE_LAST) begin
                        // key_valid/key_code are registered so they show up
                        // in the first cycle that PRESSED is current.
                        stable_d    = '0;
                        state_d     = S_PRESSED;
                        key_valid_d = 1'b1;
                        key_code_d  = {low_idx(row_pat_q), col_idx_q};
                        key_held_d  = 1'b1;
`ifdef KEYPAD_REPEAT_EN
                        rep_d       = '0;
`endif
                    end else begin
                        stable_d = stable_q + 1'b1;
                    end
                end else begin
                    stable_d = '0;
                    dwell_d  = '0;
                    col_d    = col_next;
                    state_d  = S_SCAN;
                end
            end

            S_PRESSED: begin
                // A different nonzero pattern is ignored: one key at a time.
                if (row_s == 4'b0000) begin
                    stable_d = '0;
                    state_d  = S_RELEASE;
`ifdef KEYPAD_REPEAT_EN
                    rep_d    = '0;
`endif
                end else begin
`ifdef KEYPAD_REPEAT_EN
                    if (rep_q == REPEAT_LAST) begin
                        rep_d       = '0;
                        key_valid_d = 1'b1;
                    end else begin
                        rep_d = rep_q + 1'b1;
                    end
`endif
                end
            end

            S_RELEASE: begin
                if (row_s == 4'b0000) begin
                    if (stable_q == STABLE_LAST) begin
                        stable_d   = '0;
                        dwell_d    = '0;
                        col_d      = col_next;
                        key_held_d = 1'b0;
                        state_d    = S_SCAN;
                    end else begin
                        stable_d = stable_q + 1'b1;
                    end
                end else begin
                    // Release glitch: back to PRESSED without a new pulse.
                    stable_d = '0;
                    state_d  = S_PRESSED;
`ifdef KEYPAD_REPEAT_EN
                    rep_d    = '0;
`endif
                end
            end

            default: begin
                state_d = S_SCAN;
            end
        endcase
    end

    assign kp.col       = col_q;
    assign kp.key_code  = key_code_q;
    assign kp.key_valid = key_valid_q;
    assign kp.key_held  = key_held_q;

endmodule
